addsub_key_parser: RTL and testbench
====================================

# addsub_key_parser

Sequential keystroke parser that sits directly upstream of the 5-bit add/subtract unit. It consumes an ASCII character stream, one byte per handshake: two decimal digits plus Enter for X, the same for Y, then `+` or `-` plus Enter. It presents X, Y and the add/subtract select C0 to the adder with a valid/ready handshake. Malformed input is flagged and the entry restarts from X.

## Interface
- `MAX_VAL`, default 15: largest accepted operand value; two-digit entries above it are rejected.
- `ENTER_A`, default 8'h0A: primary Enter code (LF).
- `ENTER_B`, default 8'h0D: alternate Enter code (CR).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `char_valid`  in  1  `char_data` holds a keystroke.
- `char_data`  in  8  ASCII code of the keystroke.
- `char_ready`  out  1  parser can accept a keystroke this cycle.
- `out_ready`  in  1  downstream adder stage takes the operand set.
- `op_valid`  out  1  `x`, `y`, `c0` hold a complete operand set.
- `x`  out  5  operand X, unsigned.
- `y`  out  5  operand Y, unsigned.
- `c0`  out  1  0 = add, 1 = subtract.
- `prompt`  out  2  field being entered: 0 = X, 1 = Y, 2 = operator, 3 = holding result.
- `err`  out  1  one-cycle pulse on a rejected keystroke.
- `err_code`  out  2  reason for the last error: 1 = non-digit, 2 = value > `MAX_VAL`, 3 = bad operator or missing Enter. Holds until the next error or reset.

## Operation
- A keystroke is accepted on a rising edge where `char_valid && char_ready`.
- `char_ready` = (state != HOLD) && `rst_n`.
- States and transitions:
  - XT (X tens digit) -> XO (X ones digit) -> XE (X Enter)
  - XE -> YT -> YO -> YE
  - YE -> OP (operator) -> OE (operator Enter) -> HOLD
  - HOLD -> XT
- Digit states (XT, XO, YT, YO) accept `'0'`..`'9'` (48..57). The tens digit is stored as 0..9 in a 4-bit register.
- In XO/YO the value is computed as tens*10 + ones, using 7-bit intermediate width (max 99).
  - Value > `MAX_VAL` -> error code 2.
  - Otherwise the low 5 bits go to a staging register.
- XE/YE/OE accept only `ENTER_A` or `ENTER_B`; any other byte -> error code 3.
- OP accepts only 43 (`'+'`, stage c0 = 0) or 45 (`'-'`, stage c0 = 1); anything else -> error code 3.
- A non-digit byte in any digit state -> error code 1.
- On any error:
  - `err` pulses for one cycle.
  - `err_code` is updated.
  - State returns to XT and all staged fields are discarded.
  - `x`, `y`, `c0` are unchanged.
- Entering HOLD copies the staged X, Y and c0 into `x`, `y`, `c0` and sets `op_valid`. These outputs stay stable until the handshake completes.
- In HOLD with `out_ready` = 1, on the next edge: `op_valid` -> 0 and state -> XT. `x`, `y`, `c0` keep their last values.
- `prompt` is a combinational decode of state: XT/XO/XE -> 0, YT/YO/YE -> 1, OP/OE -> 2, HOLD -> 3.

## Timing
- Reset state (`rst_n` low, asynchronous):
  - state XT, all staging registers 0.
  - `x` = 0, `y` = 0, `c0` = 0.
  - `op_valid` = 0, `err` = 0, `err_code` = 0.
  - `prompt` = 0, `char_ready` = 0.
- `char_ready` rises combinationally once `rst_n` is released.
- Reset asserted mid-entry or during HOLD aborts immediately with no partial output.
- Latency: `op_valid` is high in the cycle after the edge that accepts the operator's Enter. Minimum 8 accepted keystrokes, so 8 cycles, per operand set.
- `err` is high exactly in the cycle after the offending accept edge.
- HOLD with `out_ready` and `char_valid` both high: the handshake completes, the char is not accepted (`char_ready` = 0), and the char is accepted in XT on a later edge.
- Idle cycles (`char_valid` = 0) leave all state unchanged in every state.
- `out_ready` outside HOLD has no effect.
- Leading zero is mandatory: exactly two digits are required per operand. `'7'` followed by Enter yields error code 1.

## Test plan
- Keys `"15\n07\n-\n"` back-to-back -> `op_valid` = 1 one cycle after the last accept; `x` = 01111, `y` = 00111, `c0` = 1, `prompt` = 3, `err` never high.
- Keys `"03\n12\n+\n"`, `out_ready` held 0 for 5 cycles then 1 -> `op_valid`, `x` = 00011, `y` = 01100, `c0` = 0 stable for all held cycles; `op_valid` drops one cycle after `out_ready`; `char_ready` = 0 throughout HOLD.
- Keys `"1A"` -> `err` pulse, `err_code` = 1, `prompt` = 0. Then `"02\n02\n+\n"` -> `x` = 2, `y` = 2, `c0` = 0.
- Keys `"16\n"` with `MAX_VAL` = 15 -> `err` pulse after `'6'`, `err_code` = 2. Same input with `MAX_VAL` = 31 -> accepted, `x` = 10000.
- Keys `"05\n05\n*\n"` -> `err_code` = 3 after `'*'`; `x`/`y`/`c0` still show the prior operand set.
- `rst_n` pulsed low after `"09\n1"` -> all outputs return to reset values at once; then `"09\n01\n-\r"` -> `x` = 9, `y` = 1, `c0` = 1, confirming CR is accepted as Enter.

Source files
------------

// File: rtl/addsub_key_parser.sv
`default_nettype none
// ============================================================================
// Module   : addsub_key_parser
// Brief    : ASCII keystroke parser that assembles X, Y and add/sub select
//            for the 5-bit add/subtract unit, with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_key_parser #(
  parameter int          MAX_VAL = 15,
  parameter logic [7:0]  ENTER_A = 8'h0A,
  parameter logic [7:0]  ENTER_B = 8'h0D
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       out_ready,
  output logic       op_valid,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic       c0,
  output logic [1:0] prompt,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [3:0] c_xt   = 4'd0;
  localparam logic [3:0] c_xo   = 4'd1;
  localparam logic [3:0] c_xe   = 4'd2;
  localparam logic [3:0] c_yt   = 4'd3;
  localparam logic [3:0] c_yo   = 4'd4;
  localparam logic [3:0] c_ye   = 4'd5;
  localparam logic [3:0] c_op   = 4'd6;
  localparam logic [3:0] c_oe   = 4'd7;
  localparam logic [3:0] c_hold = 4'd8;

  localparam logic [6:0] c_max_val = 7'(MAX_VAL);
  localparam logic [7:0] c_plus    = 8'h2B;
  localparam logic [7:0] c_minus   = 8'h2D;

  logic [3:0] r_state;
  logic [3:0] r_tens;
  logic [4:0] r_sx;
  logic [4:0] r_sy;
  logic       r_sc0;

  logic       w_accept;
  logic       w_is_digit;
  logic [3:0] w_digit;
  logic [6:0] w_val;
  logic       w_is_enter;
  logic       w_fail;
  logic [1:0] w_code;

  assign char_ready = (r_state != c_hold) && rst_n;
  assign w_accept   = char_valid && char_ready;
  assign w_is_digit = (char_data >= 8'h30) && (char_data <= 8'h39);
  // ASCII '0'..'9' carry the digit value in the low nibble
  assign w_digit    = char_data[3:0];
  assign w_val      = ({3'b000, r_tens} * 7'd10) + {3'b000, w_digit};
  assign w_is_enter = (char_data == ENTER_A) || (char_data == ENTER_B);

  always_comb begin
    w_fail = 1'b0;
    w_code = 2'd0;
    case (r_state)
      c_xt, c_yt: begin
        if (!w_is_digit) begin
          w_fail = 1'b1;
          w_code = 2'd1;
        end
      end
      c_xo, c_yo: begin
        if (!w_is_digit) begin
          w_fail = 1'b1;
          w_code = 2'd1;
        end else if (w_val > c_max_val) begin
          w_fail = 1'b1;
          w_code = 2'd2;
        end
      end
      c_xe, c_ye, c_oe: begin
        if (!w_is_enter) begin
          w_fail = 1'b1;
          w_code = 2'd3;
        end
      end
      c_op: begin
        if ((char_data != c_plus) && (char_data != c_minus)) begin
          w_fail = 1'b1;
          w_code = 2'd3;
        end
      end
      default: begin
        w_fail = 1'b0;
        w_code = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_xt;
      r_tens   <= 4'd0;
      r_sx     <= 5'd0;
      r_sy     <= 5'd0;
      r_sc0    <= 1'b0;
      x        <= 5'd0;
      y        <= 5'd0;
      c0       <= 1'b0;
      op_valid <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      err <= 1'b0;
      if (w_accept) begin
        if (w_fail) begin
          // abandon the whole entry; published operands stay untouched
          err      <= 1'b1;
          err_code <= w_code;
          r_state  <= c_xt;
          r_tens   <= 4'd0;
          r_sx     <= 5'd0;
          r_sy     <= 5'd0;
          r_sc0    <= 1'b0;
        end else begin
          case (r_state)
            c_xt: begin r_tens <= w_digit;    r_state <= c_xo; end
            c_xo: begin r_sx   <= w_val[4:0]; r_state <= c_xe; end
            c_xe: r_state <= c_yt;
            c_yt: begin r_tens <= w_digit;    r_state <= c_yo; end
            c_yo: begin r_sy   <= w_val[4:0]; r_state <= c_ye; end
            c_ye: r_state <= c_op;
            c_op: begin r_sc0 <= (char_data == c_minus); r_state <= c_oe; end
            c_oe: begin
              x        <= r_sx;
              y        <= r_sy;
              c0       <= r_sc0;
              op_valid <= 1'b1;
              r_state  <= c_hold;
            end
            default: r_state <= c_xt;
          endcase
        end
      end else if ((r_state == c_hold) && out_ready) begin
        op_valid <= 1'b0;
        r_state  <= c_xt;
      end
    end
  end

  always_comb begin
    prompt = 2'd0;
    case (r_state)
      c_xt, c_xo, c_xe: prompt = 2'd0;
      c_yt, c_yo, c_ye: prompt = 2'd1;
      c_op, c_oe:       prompt = 2'd2;
      c_hold:           prompt = 2'd3;
      default:          prompt = 2'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_key_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_key_parser
// Brief    : Directed self-checking bench for addsub_key_parser (MAX_VAL 15
//            and MAX_VAL 31 instances driven from the same key stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_key_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       char_ready, op_valid, c0, err;
  logic [4:0] x, y;
  logic [1:0] prompt, err_code;

  logic       b_char_ready, b_op_valid, b_c0, b_err;
  logic [4:0] b_x, b_y;
  logic [1:0] b_prompt, b_err_code;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  addsub_key_parser #(.MAX_VAL(15)) dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .out_ready(out_ready), .op_valid(op_valid),
    .x(x), .y(y), .c0(c0), .prompt(prompt), .err(err), .err_code(err_code)
  );

  addsub_key_parser #(.MAX_VAL(31)) dut31 (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(b_char_ready), .out_ready(out_ready), .op_valid(b_op_valid),
    .x(b_x), .y(b_y), .c0(b_c0), .prompt(b_prompt), .err(b_err),
    .err_code(b_err_code)
  );

  always @(negedge clk) if (err) err_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    char_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    char_valid = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int base;

    // reset state
    #12;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_c0", c0, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_prompt", prompt, 0);
    chk("rst_char_ready", char_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", char_ready, 1);

    // 15 - 07, back-to-back
    base = err_seen;
    send_str("15\n");
    chk("t1_prompt_y", prompt, 1);
    send_str("07\n-");
    chk("t1_prompt_op", prompt, 2);
    send_str("\n");
    chk("t1_op_valid", op_valid, 1);
    chk("t1_x", x, 5'b01111);
    chk("t1_y", y, 5'b00111);
    chk("t1_c0", c0, 1);
    chk("t1_prompt_hold", prompt, 3);
    chk("t1_char_ready", char_ready, 0);
    idle(1);
    chk("t1_no_err", err_seen - base, 0);
    handshake();
    chk("t1_op_valid_drop", op_valid, 0);
    chk("t1_prompt_back", prompt, 0);
    chk("t1_x_kept", x, 5'b01111);

    // 03 + 12 held for 5 cycles, then handshake with a key pending
    send_str("03\n12\n+\n");
    @(negedge clk);
    char_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t2_hold_valid", op_valid, 1);
      chk("t2_hold_x", x, 5'b00011);
      chk("t2_hold_y", y, 5'b01100);
      chk("t2_hold_c0", c0, 0);
      chk("t2_hold_ready", char_ready, 0);
    end
    @(negedge clk);
    out_ready  = 1'b1;
    char_valid = 1'b1;
    char_data  = "0";
    @(posedge clk);
    #1;
    chk("t2_drop", op_valid, 0);
    chk("t2_ready_xt", char_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    base = err_seen;
    send_str("4\n01\n+\n");
    chk("t2_pending_x", x, 4);
    chk("t2_pending_y", y, 1);
    chk("t2_pending_err", err_seen - base, 0);
    handshake();

    // non-digit, then recovery
    send_str("1A");
    chk("t3_err", err, 1);
    chk("t3_code", err_code, 1);
    chk("t3_prompt", prompt, 0);
    chk("t3_x_kept", x, 4);
    idle(1);
    chk("t3_err_pulse", err, 0);
    send_str("02\n02\n+\n");
    chk("t3_x", x, 2);
    chk("t3_y", y, 2);
    chk("t3_c0", c0, 0);
    handshake();

    // bad operator keeps prior operands
    send_str("05\n05\n*");
    chk("t5_err", err, 1);
    chk("t5_code", err_code, 3);
    chk("t5_x", x, 2);
    chk("t5_y", y, 2);
    chk("t5_c0", c0, 0);
    chk("t5_prompt", prompt, 0);

    // missing leading zero
    send_str("7\n");
    chk("lz_err", err, 1);
    chk("lz_code", err_code, 1);

    // missing Enter after a digit pair
    send_str("05x");
    chk("ne_code", err_code, 3);

    // range limit: 16 rejected at 15, accepted at 31
    send_str("16");
    chk("t4_err15", err, 1);
    chk("t4_code15", err_code, 2);
    chk("t4_err31", b_err, 0);
    send_str("\n");
    chk("t4_prompt31", b_prompt, 1);
    send_str("00\n+\n");
    chk("t4_valid31", b_op_valid, 1);
    chk("t4_x31", b_x, 5'b10000);
    chk("t4_y31", b_y, 0);
    chk("t4_valid15", op_valid, 0);
    handshake();

    // reset mid-entry, then CR as Enter with idle gaps
    send_str("09\n1");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_x", x, 0);
    chk("t6_rst_y", y, 0);
    chk("t6_rst_prompt", prompt, 0);
    chk("t6_rst_code", err_code, 0);
    chk("t6_rst_ready", char_ready, 0);
    chk("t6_rst_x31", b_x, 0);
    @(negedge clk);
    rst_n = 1'b1;
    char_valid = 1'b0;
    send_str("09");
    idle(3);
    chk("t6_idle_prompt", prompt, 0);
    send_str("\n01");
    idle(2);
    chk("t6_idle_prompt_y", prompt, 1);
    send_str("\n-\r");
    chk("t6_valid", op_valid, 1);
    chk("t6_x", x, 9);
    chk("t6_y", y, 1);
    chk("t6_c0", c0, 1);
    handshake();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
